instr_loader: RTL and testbench
===============================

# instr_loader

Program loader that writes the CPU's instruction memory: it accepts a byte stream over a valid/ready handshake, packs bytes MSB-first into 32-bit instruction words and issues one write per word at sequential addresses from 0. It sits beside the instruction memory as its write-side master, the opposite end of the PC-driven fetch path. It asserts `cpu_hold` to keep the CPU out of fetch while a program loads.

## Interface
- `ADDR_W`, 8, instruction-memory address width (matches the 8-bit PC)
- `DATA_W`, 32, instruction word width; fixed at 4 bytes
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins a load
- `byte_in`  in  8  stream byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  DATA_W  write data
- `cpu_hold`  out  1  CPU must not fetch
- `done`  out  1  load completed successfully
- `error`  out  1  load aborted with a checksum mismatch
- `word_count`  out  ADDR_W+1  words written in the current or last load

## Operation
- States: IDLE, LEN, DATA, WRITE, CHECK, DONE, ERR.
- A byte is accepted when `byte_valid && byte_ready`. `byte_ready` is 1 only in LEN, DATA and CHECK.
- IDLE, DONE or ERR + `start`:
  - go to LEN
  - clear `word_count`, the byte index, the checksum, `done` and `error`
  - `start` in any other state is ignored.
- LEN: the accepted byte is N, the word count. N=0 means 2**ADDR_W words. Go to DATA.
- DATA:
  - each accepted byte shifts into the low end of the word register (first byte lands in [31:24])
  - the byte index runs 0..3
  - on the 4th byte go to WRITE.
- WRITE, exactly one cycle:
  - `mem_we`=1, `mem_addr`=`word_count`[ADDR_W-1:0], `mem_wdata`=packed word
  - then `word_count`++
  - if `word_count`+1 == N go to CHECK, or to DONE when the checksum is compiled out; otherwise go to DATA.
- CHECK: the accepted byte is compared with the XOR of all data bytes (the length byte is excluded). Equal → DONE, unequal → ERR.
- DONE: `done`=1 and `cpu_hold`=0 until the next `start`.
- ERR: `error`=1 and `cpu_hold` stays 1 until the next `start`. Memory contents are left as written.
- `cpu_hold`=1 in LEN, DATA, WRITE, CHECK and ERR.
- The address never wraps within a load; the maximum is 2**ADDR_W-1.
- `rst_n` low mid-load: the state returns to IDLE immediately. No partial word is written, and memory keeps any words already written.

## Timing
- Reset values:
  - state IDLE
  - `byte_ready`, `mem_we`, `cpu_hold`, `done`, `error` all 0
  - `mem_addr`, `mem_wdata`, `word_count` all 0.
- All outputs are registered except `byte_ready`, which is decoded from state.
- `start` at edge k → LEN at k+1, `byte_ready`=1 and `cpu_hold`=1 from k+1.
- 4th byte of a word accepted at edge k → `mem_we`=1 during cycle k+1 → next byte can be accepted at edge k+2.
- Minimum per word: 5 cycles. Minimum total: 1 + 5N + 1 (checksum) cycles after `start`.
- `byte_valid` may deassert at any time; the loader simply waits, with no timeout.
- `done`/`error` rise one cycle after the final accepted byte (checksum build) or one cycle after the last WRITE (no-checksum build).

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - CHECK state exists and a trailing XOR checksum byte is required
  - `error` is functional.
- Undefined:
  - CHECK and ERR are removed
  - the last WRITE goes straight to DONE
  - `error` is tied to 0
  - no byte follows the last data byte.

## Structure
- `instr_loader_pkg` holds:
  - the state enum `loader_state_t`
  - `BYTES_PER_WORD`=4
  - the default `ADDR_W`/`DATA_W` constants shared with the instruction memory and PC.
- One sub-module, `word_packer`. It takes the byte shift register and 2-bit index, and produces the `word_full` flag and the packed word. It is cleared on `start`.

## Test plan
- Load N=1, bytes 0x20,0x08,0x00,0x05, checksum 0x2D → one write at addr 0, data 0x20080005. Then `done`=1, `cpu_hold`=0, `word_count`=1.
- N=3 with `byte_valid` toggling every other cycle → writes at addr 0,1,2 in order. No byte is dropped or duplicated, and `byte_ready` is 0 during each WRITE cycle.
- N=1 with a wrong checksum of 0x00 → the word is written, then `error`=1, `done`=0, `cpu_hold` held 1. A following `start` clears `error`.
- N=0 (256 words) → the last write is at addr 0xFF, `word_count`=256, with no address wrap.
- `rst_n` low after 2 data bytes → all outputs 0 asynchronously and no `mem_we`. A new `start` restarts from addr 0.
- `start` pulsed while in DATA → ignored, and the load completes normally.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared constants, FSM state type and state decode helpers
// for the program loader. Optional macro: INSTR_LOADER_CHECKSUM_EN adds the
// CHECK/ERR states used by the trailing XOR checksum byte.
package instr_loader_pkg;

  // Defaults shared with the instruction memory and the 8-bit PC.
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    S_CHECK = 3'd5,
    S_ERR   = 3'd6
`endif
  } loader_state_t;

  // States in which a stream byte is consumed.
  function automatic logic accepts_byte(input loader_state_t s);
    logic r;
    r = (s == S_LEN) || (s == S_DATA);
`ifdef INSTR_LOADER_CHECKSUM_EN
    r = r || (s == S_CHECK);
`endif
    return r;
  endfunction

  // States from which a start pulse begins a new load.
  function automatic logic start_allowed(input loader_state_t s);
    logic r;
    r = (s == S_IDLE) || (s == S_DONE);
`ifdef INSTR_LOADER_CHECKSUM_EN
    r = r || (s == S_ERR);
`endif
    return r;
  endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// word_packer: packs bytes MSB-first into an instruction word.
// Latency: o_word/o_word_full are combinational on the byte being pushed, so
// the complete word is available in the same cycle its 4th byte is accepted.
module word_packer
  import instr_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  output logic              o_word_full,
  output logic [DATA_W-1:0] o_word
);

  // Only the first three bytes of a word need storing; the fourth is the
  // byte on i_byte when the word completes.
  localparam int SHR_W = DATA_W - BYTE_W;

  logic [SHR_W-1:0] r_shreg;
  logic [1:0]       r_idx;

  // Shift accepted bytes in at the low end and track the byte index 0..3.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (i_push) begin
      r_shreg <= {r_shreg[SHR_W-BYTE_W-1:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  assign o_word_full = i_push && (r_idx == 2'(BYTES_PER_WORD - 1));
  assign o_word      = {r_shreg, i_byte};

endmodule

// File: rtl/instr_loader.sv
// instr_loader: byte-stream program loader, write-side master of the
// instruction memory. 4th byte of a word accepted at edge k -> mem_we during
// cycle k+1; byte_ready drops in WRITE/IDLE/DONE/ERR, stream waits indefinitely.
// Optional macro INSTR_LOADER_CHECKSUM_EN: trailing XOR checksum byte, error.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam int CNT_W = ADDR_W + 1;
  // A length byte of 0 stands for a full memory of 2**ADDR_W words.
  localparam logic [CNT_W-1:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_word_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_done;

  logic              w_accept;
  logic              w_clear;
  logic              w_push;
  logic              w_word_full;
  logic [DATA_W-1:0] w_word;
  logic [CNT_W-1:0]  w_count_nxt;

  assign o_byte_ready = accepts_byte(r_state);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_clear      = i_start && start_allowed(r_state);
  assign w_push       = w_accept && (r_state == S_DATA);
  assign w_count_nxt  = r_word_count + CNT_W'(1);

  word_packer #(
    .DATA_W(DATA_W)
  ) u_word_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_byte      (i_byte_in),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_error;

  // Running XOR over data bytes only; the length byte is not included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= '0;
    end else if (w_clear) begin
      r_csum <= '0;
    end else if (w_push) begin
      r_csum <= r_csum ^ i_byte_in;
    end
  end

  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif

  // Load sequencer; all status and memory-write outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_count <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b0;
      r_done       <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_error      <= 1'b0;
`endif
    end else begin
      // The write strobe is a single-cycle pulse.
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state      <= S_LEN;
            r_word_count <= '0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_ERR: begin
          if (i_start) begin
            r_state      <= S_LEN;
            r_word_count <= '0;
            r_cpu_hold   <= 1'b1;
            r_error      <= 1'b0;
          end
        end
`endif
        S_LEN: begin
          if (w_accept) begin
            r_len   <= (i_byte_in == 8'd0) ? MAX_WORDS : CNT_W'(i_byte_in);
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_word_full) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_count[ADDR_W-1:0];
            r_mem_wdata <= w_word;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_word_count <= w_count_nxt;
          if (w_count_nxt == r_len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_state    <= S_CHECK;
`else
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
`endif
          end else begin
            r_state <= S_DATA;
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            if (i_byte_in == r_csum) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              // Hold stays asserted: the memory image is incomplete/untrusted.
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader; inputs driven and outputs
// sampled on the falling clock edge, every memory write logged by a monitor.
// Works in both builds (INSTR_LOADER_CHECKSUM_EN defined or not).
module tb_instr_loader;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [8:0]  o_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log filled by the monitor.
  logic [7:0]  wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_cnt = 0;
  int          rdy_in_we = 0;

  instr_loader dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_word_count (o_word_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_mem_we) begin
      if (wr_cnt < 1024) begin
        wr_addr[wr_cnt] = o_mem_addr;
        wr_data[wr_cnt] = o_mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
      if (o_byte_ready) rdy_in_we = rdy_in_we + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input logic [31:0] first);
    logic [7:0] k;
    k = 8'(i);
    return (i == 0) ? first : {k, ~k, k ^ 8'h3C, 8'h5A};
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Present one byte, wait for ready, return at the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      i_byte_valid = 1'b0;
      @(negedge i_clk);
    end
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    t = 0;
    while (!o_byte_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'(o_byte_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
  endtask

  // Full load: start, length byte, data words, then checksum (or the extra
  // cycle until done in the no-checksum build).
  task automatic do_load(input int n, input bit gap, input bit bad, input bit mid_start,
                         input logic [31:0] first);
    logic [31:0] w;
    logic [7:0]  csum;
    logic [7:0]  b;
    int          nw;
    nw   = (n == 0) ? 256 : n;
    csum = 8'h00;
    pulse_start();
    send_byte(8'(n), gap);
    for (int i = 0; i < nw; i++) begin
      w = word_of(i, first);
      for (int j = 0; j < 4; j++) begin
        b    = w[31-8*j -: 8];
        csum = csum ^ b;
        send_byte(b, gap);
        if (mid_start && i == 0 && j == 1) pulse_start();
      end
      check("we_after_4th", 32'(o_mem_we), 32'd1);
      check("addr_after_4th", 32'(o_mem_addr), 32'(i & 255));
      check("wdata_after_4th", o_mem_wdata, w);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(bad ? 8'h00 : csum, gap);
`else
    if (bad) check("bad_csum_unsupported", 32'd0, 32'd0 + 32'(bad));
    @(negedge i_clk);
`endif
  endtask

  task automatic check_done(input string tag, input int wc);
    check({tag, "_done"}, 32'(o_done), 32'd1);
    check({tag, "_hold"}, 32'(o_cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(o_error), 32'd0);
    check({tag, "_wc"}, 32'(o_word_count), 32'(wc));
    check({tag, "_rdy"}, 32'(o_byte_ready), 32'd0);
  endtask

  initial begin
    int base;
    int bad_seq;
    i_rst_n      = 1'b1;
    i_start      = 1'b0;
    i_byte_in    = 8'h00;
    i_byte_valid = 1'b0;
    #3 i_rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(o_byte_ready), 32'd0);
    check("rst_we", 32'(o_mem_we), 32'd0);
    check("rst_hold", 32'(o_cpu_hold), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    check("rst_addr", 32'(o_mem_addr), 32'd0);
    check("rst_wdata", o_mem_wdata, 32'd0);
    check("rst_wc", 32'(o_word_count), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Start latency: LEN one edge after start.
    pulse_start();
    check("start_ready", 32'(o_byte_ready), 32'd1);
    check("start_hold", 32'(o_cpu_hold), 32'd1);
    check("start_done", 32'(o_done), 32'd0);

    // N=1, 0x20 0x08 0x00 0x05, checksum 0x2D.
    base = wr_cnt;
    do_load(1, 1'b0, 1'b0, 1'b0, 32'h20080005);
    check_done("t1", 1);
    check("t1_nwr", 32'(wr_cnt - base), 32'd1);
    check("t1_addr", 32'(wr_addr[base]), 32'h00);
    check("t1_data", wr_data[base], 32'h20080005);

    // N=3 with byte_valid toggling every other cycle.
    base = wr_cnt;
    do_load(3, 1'b1, 1'b0, 1'b0, 32'hCAFE0001);
    check_done("t2", 3);
    check("t2_nwr", 32'(wr_cnt - base), 32'd3);
    check("t2_addr0", 32'(wr_addr[base]), 32'h00);
    check("t2_addr1", 32'(wr_addr[base+1]), 32'h01);
    check("t2_addr2", 32'(wr_addr[base+2]), 32'h02);
    check("t2_data0", wr_data[base], 32'hCAFE0001);
    check("t2_data1", wr_data[base+1], 32'h01FE3D5A);
    check("t2_data2", wr_data[base+2], 32'h02FD3E5A);
    check("t2_rdy_in_write", 32'(rdy_in_we), 32'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Wrong checksum: word written, error latched, hold kept.
    base = wr_cnt;
    do_load(1, 1'b0, 1'b1, 1'b0, 32'h11223344);
    check("t3_nwr", 32'(wr_cnt - base), 32'd1);
    check("t3_data", wr_data[base], 32'h11223344);
    check("t3_error", 32'(o_error), 32'd1);
    check("t3_done", 32'(o_done), 32'd0);
    check("t3_hold", 32'(o_cpu_hold), 32'd1);
    @(negedge i_clk);
    check("t3_error_stays", 32'(o_error), 32'd1);
    pulse_start();
    check("t3_error_clr", 32'(o_error), 32'd0);
    check("t3_hold_restart", 32'(o_cpu_hold), 32'd1);
`endif

    // N=0 means 256 words; last address 0xFF, no wrap.
    base = wr_cnt;
    do_load(0, 1'b0, 1'b0, 1'b0, 32'hA0B0C0D0);
    check_done("t4", 256);
    check("t4_nwr", 32'(wr_cnt - base), 32'd256);
    check("t4_last_addr", 32'(wr_addr[base+255]), 32'hFF);
    check("t4_last_data", wr_data[base+255], 32'hFF00C35A);
    bad_seq = 0;
    for (int j = 0; j < 256; j++)
      if (wr_addr[base+j] != 8'(j)) bad_seq++;
    check("t4_addr_seq", 32'(bad_seq), 32'd0);

    // Asynchronous reset after two data bytes.
    base = wr_cnt;
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_ready", 32'(o_byte_ready), 32'd0);
    check("t5_hold", 32'(o_cpu_hold), 32'd0);
    check("t5_addr", 32'(o_mem_addr), 32'd0);
    check("t5_wdata", o_mem_wdata, 32'd0);
    check("t5_wc", 32'(o_word_count), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("t5_no_write", 32'(wr_cnt - base), 32'd0);
    do_load(1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    check_done("t5b", 1);
    check("t5b_addr", 32'(wr_addr[base]), 32'h00);
    check("t5b_data", wr_data[base], 32'hDEADBEEF);

    // Start pulsed while in DATA is ignored.
    base = wr_cnt;
    do_load(2, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    check_done("t6", 2);
    check("t6_nwr", 32'(wr_cnt - base), 32'd2);
    check("t6_data0", wr_data[base], 32'h0BADF00D);
    check("t6_addr1", 32'(wr_addr[base+1]), 32'h01);
    check("t6_data1", wr_data[base+1], 32'h01FE3D5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
